// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle for the hazard/forwarding unit: the decode instruction
// going in, stall request, forwarding selects and the stall counter coming out.
interface hazard_scoreboard_if #(
    parameter int DEPTH = 3
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic             id_valid;
    logic [31:0]      id_instr;
    logic             flush;
    logic             stall;
    logic [SEL_W-1:0] fwd_a;
    logic [SEL_W-1:0] fwd_b;
    logic             fwd_a_ld;
    logic             fwd_b_ld;
    logic [15:0]      stall_cnt;

    // Decode stage side: presents the instruction, consumes stall/forwarding.
    modport master (
        output id_valid, id_instr, flush,
        input  stall, fwd_a, fwd_b, fwd_a_ld, fwd_b_ld, stall_cnt
    );

    // Hazard unit side.
    modport slave (
        input  id_valid, id_instr, flush,
        output stall, fwd_a, fwd_b, fwd_a_ld, fwd_b_ld, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding unit beside decode. A shift-register scoreboard holds
// {valid, dest, is_load} for the last DEPTH issued instructions (slot 1 = EX).
// Forwarding selects pick the youngest producer per source; a load that is
// too young to forward (slot < LOAD_SLOT) raises a load-use stall.
module hazard_scoreboard #(
    parameter int DEPTH     = 3,
    parameter int LOAD_SLOT = 2
) (
    input logic                clk,
    input logic                rst_n,
    hazard_scoreboard_if.slave sb
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // Scoreboard slots, index = distance past decode.
    logic [DEPTH:1] vld_q;
    logic [DEPTH:1] ld_q;
    logic [4:0]     dest_q [DEPTH:1];
    logic [15:0]    cnt_q;

    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       id_dest;
    logic             use_a;
    logic             use_b;
    logic             id_load;
    logic [SEL_W-1:0] fwd_a;
    logic [SEL_W-1:0] fwd_b;
    logic             ld_a;
    logic             ld_b;
    logic             late_a;
    logic             late_b;
    logic             stall;
    logic             slot1_vld_d;

    // Classify the decode instruction into used sources, destination and load flag.
    always_comb begin
        rs      = sb.id_instr[25:21];
        rt      = sb.id_instr[20:16];
        use_a   = 1'b0;
        use_b   = 1'b0;
        id_dest = 5'd0;
        id_load = 1'b0;
        case (sb.id_instr[31:26])
            OP_RTYPE: begin
                use_a   = 1'b1;
                use_b   = 1'b1;
                id_dest = sb.id_instr[15:11];
            end
            OP_LW: begin
                use_a   = 1'b1;
                id_dest = sb.id_instr[20:16];
                id_load = 1'b1;
            end
            OP_SW, OP_BEQ: begin
                use_a = 1'b1;
                use_b = 1'b1;
            end
            default: ;
        endcase
    end

    // Youngest-match search: scan oldest to youngest so the lowest slot wins.
    // A $0 source never matches, which also makes a recorded dest of $0 inert.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (use_a && rs != 5'd0 && vld_q[k] && dest_q[k] == rs) begin
                fwd_a = SEL_W'(k);
                ld_a  = ld_q[k];
            end
            if (use_b && rt != 5'd0 && vld_q[k] && dest_q[k] == rt) begin
                fwd_b = SEL_W'(k);
                ld_b  = ld_q[k];
            end
        end
    end

    // Load data is only usable once the load reaches LOAD_SLOT; flush overrides.
    assign late_a      = ld_a && (int'(fwd_a) < LOAD_SLOT);
    assign late_b      = ld_b && (int'(fwd_b) < LOAD_SLOT);
    assign stall       = sb.id_valid && !sb.flush && (late_a || late_b);
    assign slot1_vld_d = sb.id_valid && !sb.flush && !stall;

    assign sb.stall     = stall;
    assign sb.fwd_a     = fwd_a;
    assign sb.fwd_b     = fwd_b;
    assign sb.fwd_a_ld  = ld_a;
    assign sb.fwd_b_ld  = ld_b;
    assign sb.stall_cnt = cnt_q;

    // Slot valid bits shift every edge (bubble into slot 1 when not issuing); saturating stall counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cnt_q <= 16'd0;
        end else begin
            vld_q <= {vld_q[DEPTH-1:1], slot1_vld_d};
            if (stall && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    // Slot payload shifts alongside the valid bits; it is ignored while invalid.
    always_ff @(posedge clk) begin
        dest_q[1] <= id_dest;
        ld_q[1]   <= id_load;
        for (int k = DEPTH; k >= 2; k--) begin
            dest_q[k] <= dest_q[k-1];
            ld_q[k]   <= ld_q[k-1];
        end
    end
endmodule
